// File: rtl/control_pkg.sv
// control_pkg: opcode, func and ALU-control encodings shared by the decoder blocks.
package control_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
endpackage

// File: rtl/control_unit_alu_decoder.sv
// alu_decoder: combinational Opcode/Func to ALU operation; flags unsupported encodings.
module alu_decoder
  import control_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic [5:0] Func,
  output logic [3:0] ALUControl,
  output logic       alu_illegal
);
  // Illegal encodings leave ALUControl at ALU_AND (0000).
  always_comb begin
    ALUControl  = ALU_AND;
    alu_illegal = 1'b0;
    case (Opcode)
      OP_RTYPE:
        case (Func)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_XOR:  ALUControl = ALU_XOR;
          FN_NOR:  ALUControl = ALU_NOR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: alu_illegal = 1'b1;
        endcase
      OP_ADDI: ALUControl = ALU_ADD;
      OP_SLTI: ALUControl = ALU_SLT;
      OP_ANDI: ALUControl = ALU_AND;
      OP_ORI:  ALUControl = ALU_OR;
      OP_XORI: ALUControl = ALU_XOR;
      default: alu_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: registered main + ALU decoder; datapath controls follow the sampled instruction by one cycle.
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Func,
  input  logic       in_valid,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       out_valid,
  output logic       illegal
);
  logic [3:0] w_alu;
  logic       w_ill;
  logic       w_rtype;
  logic       r_alusrc, r_regdst, r_regwrite, r_valid, r_ill;
  logic [3:0] r_alu;
  alu_decoder u_alu_dec (
    .Opcode      (Opcode),
    .Func        (Func),
    .ALUControl  (w_alu),
    .alu_illegal (w_ill)
  );
  assign w_rtype = Opcode == OP_RTYPE;
  // Datapath selects hold across invalid cycles; write/valid/illegal strobes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_regwrite <= 1'b0;
      r_alu      <= ALU_AND;
      r_valid    <= 1'b0;
      r_ill      <= 1'b0;
    end else begin
      r_valid    <= in_valid;
      r_regwrite <= in_valid & ~w_ill;
      r_ill      <= in_valid & w_ill;
      if (in_valid) begin
        r_alusrc <= ~w_ill & ~w_rtype;
        r_regdst <= ~w_ill & w_rtype;
        r_alu    <= w_alu;
      end
    end
  end
  assign ALUSrc     = r_alusrc;
  assign RegDst     = r_regdst;
  assign RegWrite   = r_regwrite;
  assign ALUControl = r_alu;
  assign out_valid  = r_valid;
  assign illegal    = r_ill;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + random stimulus against a table-driven instruction model.
module tb_control_unit;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [5:0] Opcode = '0, Func = '0;
  logic       ALUSrc, RegDst, RegWrite, out_valid, illegal;
  logic [3:0] ALUControl;
  logic [8:0] w_dut, m;
  int         n_vec = 0, n_bad = 0;
  typedef struct {logic [5:0] op; logic [5:0] fn; logic [3:0] alu;} ins_t;
  ins_t tbl[12];

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .Opcode     (Opcode),
    .Func       (Func),
    .in_valid   (in_valid),
    .ALUSrc     (ALUSrc),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;
  assign w_dut = {out_valid, illegal, RegWrite, RegDst, ALUSrc, ALUControl};

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {ov,ill,rw,rd,src,alu}=%b expected %b", tag, got, exp);
    end
  endtask

  // Expected outputs as {out_valid, illegal, RegWrite, RegDst, ALUSrc, ALUControl[3:0]}.
  function automatic logic [8:0] model(input logic [8:0] prev, input logic v,
                                       input logic [5:0] op, input logic [5:0] fn);
    if (!v) return {3'b000, prev[5:0]};
    foreach (tbl[i])
      if (tbl[i].op == op && (op != 6'd0 || tbl[i].fn == fn))
        return {1'b1, 1'b0, 1'b1, op == 6'd0, op != 6'd0, tbl[i].alu};
    return 9'b110_000000;
  endfunction

  task automatic step(input string tag, input logic v, input logic [5:0] op, input logic [5:0] fn);
    in_valid = v; Opcode = op; Func = fn;
    @(posedge clk);
    m = model(m, v, op, fn);
    #1 chk(tag, w_dut, m);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk(tag, w_dut, 9'd0);
    m = '0;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{6'b000000, 6'b100000, 4'b0010};
    tbl[1]  = '{6'b000000, 6'b100010, 4'b0110};
    tbl[2]  = '{6'b000000, 6'b100100, 4'b0000};
    tbl[3]  = '{6'b000000, 6'b100101, 4'b0001};
    tbl[4]  = '{6'b000000, 6'b100110, 4'b0011};
    tbl[5]  = '{6'b000000, 6'b100111, 4'b1100};
    tbl[6]  = '{6'b000000, 6'b101010, 4'b0111};
    tbl[7]  = '{6'b001000, 6'b000000, 4'b0010};
    tbl[8]  = '{6'b001010, 6'b000000, 4'b0111};
    tbl[9]  = '{6'b001100, 6'b000000, 4'b0000};
    tbl[10] = '{6'b001101, 6'b000000, 4'b0001};
    tbl[11] = '{6'b001110, 6'b000000, 4'b0011};
    m = '0;
    #1 chk("reset", w_dut, 9'd0);
    @(negedge clk) rst = 1'b0;
    step("idle0", 1'b0, 6'd0, 6'd0);
    step("idle1", 1'b0, 6'd0, 6'd0);
    step("init_illegal", 1'b1, 6'd0, 6'd0);
    for (int i = 0; i < 7; i++) step("rtype", 1'b1, 6'd0, tbl[i].fn);
    for (int i = 7; i < 12; i++) step("itype", 1'b1, tbl[i].op, 6'd0);
    for (int i = 0; i < 3; i++) step("addi_rep", 1'b1, 6'b001000, 6'd0);
    step("ill_r", 1'b1, 6'b000000, 6'b000000);
    step("ill_op", 1'b1, 6'b111111, 6'b100000);
    step("gap_addi", 1'b1, 6'b001000, 6'd0);
    step("gap0", 1'b0, 6'b000000, 6'b100100);
    step("gap1", 1'b0, 6'b111111, 6'd0);
    step("after_gap_and", 1'b1, 6'b000000, 6'b100100);
    step("pre_rst", 1'b1, 6'b001101, 6'd0);
    async_reset("mid_rst");
    step("post_rst", 1'b1, 6'b000000, 6'b100111);
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [5:0] op, fn;
      k = $urandom_range(0, 11);
      op = tbl[k].op;
      fn = (op == 6'd0) ? tbl[k].fn : 6'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        op = 6'($urandom_range(0, 1) ? 0 : $urandom);
        fn = 6'($urandom);
      end
      step("rand", $urandom_range(0, 9) < 7, op, fn);
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
